// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl
//  Purpose  : Pong game sequencer. Detects paddle and wall bounces, runs the
//             serve / play / point / game-over flow and keeps both scores.
//  Revision : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int PADDLE_H    = 100,
    parameter int PADDLE_W    = 10,
    parameter int BALL_SIZE   = 20,
    parameter int P1_X        = 30,
    parameter int P2_X        = 600,
    parameter int LEFT_MISS   = 25,
    parameter int RIGHT_MISS  = 610,
    parameter int TOP_Y       = 0,
    parameter int BOTTOM_Y    = 460,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic [8:0] p1_y,
    input  logic [8:0] p2_y,
    output logic       ball_en,
    output logic       ball_restart,
    output logic       h_col,
    output logic       v_col,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Geometry widened to 11 bits so that coordinate + size never wraps.
    localparam logic [10:0] c_P1_LEFT    = 11'(P1_X);
    localparam logic [10:0] c_P1_RIGHT   = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] c_P2_LEFT    = 11'(P2_X);
    localparam logic [10:0] c_P2_RIGHT   = 11'(P2_X + PADDLE_W);
    localparam logic [10:0] c_BALL       = 11'(BALL_SIZE);
    localparam logic [10:0] c_PAD_H      = 11'(PADDLE_H);
    localparam logic [10:0] c_LEFT_MISS  = 11'(LEFT_MISS);
    localparam logic [10:0] c_RIGHT_MISS = 11'(RIGHT_MISS);
    localparam logic [10:0] c_TOP        = 11'(TOP_Y);
    localparam logic [10:0] c_BOTTOM     = 11'(BOTTOM_Y);
    localparam logic [3:0]  c_WIN        = 4'(WIN_SCORE);
    localparam int          c_CNT_W      = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_SERVE_LAST = c_CNT_W'(SERVE_TICKS - 1);

    state_t               r_state,     w_state_next;
    logic                 r_start_q;
    logic                 r_dir_x,     w_dir_x_next;
    logic                 r_dir_y,     w_dir_y_next;
    logic [c_CNT_W-1:0]   r_serve_cnt, w_serve_cnt_next;
    logic [3:0]           r_p1_score,  w_p1_score_next;
    logic [3:0]           r_p2_score,  w_p2_score_next;
    logic                 r_winner,    w_winner_next;
    logic                 r_h_col,     w_h_col_next;
    logic                 r_v_col,     w_v_col_next;
    logic                 r_restart,   w_restart_next;

    logic [10:0] w_bx, w_by, w_p1y, w_p2y;
    logic        w_start_rise;
    logic        w_hit1, w_hit2, w_hit, w_wall;
    logic        w_miss_l, w_miss_r, w_miss_taken;

    assign w_bx  = {1'b0, ball_x};
    assign w_by  = {2'b0, ball_y};
    assign w_p1y = {2'b0, p1_y};
    assign w_p2y = {2'b0, p2_y};

    assign w_start_rise = start & ~r_start_q;

    // Direction qualifiers keep a lingering overlap from bouncing twice.
    assign w_hit1 = ~r_dir_x
                  & (w_bx <= c_P1_RIGHT) & (w_bx + c_BALL >= c_P1_LEFT)
                  & (w_by + c_BALL >= w_p1y) & (w_by <= w_p1y + c_PAD_H);
    assign w_hit2 = r_dir_x
                  & (w_bx + c_BALL >= c_P2_LEFT) & (w_bx <= c_P2_RIGHT)
                  & (w_by + c_BALL >= w_p2y) & (w_by <= w_p2y + c_PAD_H);
    assign w_hit  = w_hit1 | w_hit2;
    assign w_wall = (~r_dir_y & (w_by <= c_TOP)) | (r_dir_y & (w_by >= c_BOTTOM));

    assign w_miss_l     = (w_bx < c_LEFT_MISS);
    assign w_miss_r     = (w_bx > c_RIGHT_MISS);
    // A point ends PLAY, so a simultaneous wall pulse would land outside PLAY.
    assign w_miss_taken = ~w_hit & (w_miss_l | w_miss_r);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_serve_cnt <= '0;
            r_p1_score  <= 4'd0;
            r_p2_score  <= 4'd0;
            r_winner    <= 1'b0;
            r_h_col     <= 1'b0;
            r_v_col     <= 1'b0;
            r_restart   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_start_q   <= start;
            r_dir_x     <= w_dir_x_next;
            r_dir_y     <= w_dir_y_next;
            r_serve_cnt <= w_serve_cnt_next;
            r_p1_score  <= w_p1_score_next;
            r_p2_score  <= w_p2_score_next;
            r_winner    <= w_winner_next;
            r_h_col     <= w_h_col_next;
            r_v_col     <= w_v_col_next;
            r_restart   <= w_restart_next;
        end
    end

    // Next-state, bounce and scoring decisions.
    always_comb begin
        w_state_next     = r_state;
        w_dir_x_next     = r_dir_x;
        w_dir_y_next     = r_dir_y;
        w_serve_cnt_next = r_serve_cnt;
        w_p1_score_next  = r_p1_score;
        w_p2_score_next  = r_p2_score;
        w_winner_next    = r_winner;
        w_h_col_next     = 1'b0;
        w_v_col_next     = 1'b0;
        w_restart_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    w_state_next   = S_SERVE;
                    w_restart_next = 1'b1;
                end
            end
            S_SERVE: begin
                if (tick) begin
                    if (r_serve_cnt == c_SERVE_LAST) begin
                        w_serve_cnt_next = '0;
                        w_state_next     = S_PLAY;
                    end else begin
                        w_serve_cnt_next = r_serve_cnt + c_CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (w_hit) begin
                        w_h_col_next = 1'b1;
                        w_dir_x_next = ~r_dir_x;
                    end else if (w_miss_l) begin
                        if (r_p2_score != c_WIN) w_p2_score_next = r_p2_score + 4'd1;
                        w_dir_x_next = 1'b0;
                        w_state_next = S_POINT;
                    end else if (w_miss_r) begin
                        if (r_p1_score != c_WIN) w_p1_score_next = r_p1_score + 4'd1;
                        w_dir_x_next = 1'b1;
                        w_state_next = S_POINT;
                    end
                    if (w_wall) begin
                        w_dir_y_next = ~r_dir_y;
                        w_v_col_next = ~w_miss_taken;
                    end
                end
            end
            S_POINT: begin
                if ((r_p1_score == c_WIN) || (r_p2_score == c_WIN)) begin
                    w_winner_next = (r_p2_score == c_WIN);
                    w_state_next  = S_OVER;
                end else begin
                    w_restart_next = 1'b1;
                    w_dir_y_next   = 1'b1;
                    w_state_next   = S_SERVE;
                end
            end
            S_OVER: begin
                if (w_start_rise) begin
                    w_p1_score_next = 4'd0;
                    w_p2_score_next = 4'd0;
                    w_dir_x_next    = 1'b1;
                    w_dir_y_next    = 1'b1;
                    w_winner_next   = 1'b0;
                    w_restart_next  = 1'b1;
                    w_state_next    = S_SERVE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign ball_en      = (r_state == S_PLAY);
    assign game_over    = (r_state == S_OVER);
    assign ball_restart = r_restart;
    assign h_col        = r_h_col;
    assign v_col        = r_v_col;
    assign p1_score     = r_p1_score;
    assign p2_score     = r_p2_score;
    assign winner       = r_winner;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_game_ctrl
//  Purpose  : Self-checking bench for pong_game_ctrl: directed scenarios plus
//             randomized play compared against a behavioural game model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int WIN   = 9;
    localparam int SERVE = 60;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [8:0] p1_y;
    logic [8:0] p2_y;
    logic       ball_en, ball_restart, h_col, v_col, game_over, winner;
    logic [3:0] p1_score, p2_score;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural game model
    int m_state, m_p1, m_p2, m_dx, m_dy, m_cnt, m_start_q;
    int m_h, m_v, m_rp, m_winner;

    logic [16:0] dut_vec;
    assign dut_vec = {ball_en, ball_restart, h_col, v_col, p1_score, p2_score,
                      game_over, winner, state};

    pong_game_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .start        (start),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .p1_y         (p1_y),
        .p2_y         (p2_y),
        .ball_en      (ball_en),
        .ball_restart (ball_restart),
        .h_col        (h_col),
        .v_col        (v_col),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .game_over    (game_over),
        .winner       (winner),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] model_vec();
        logic [16:0] v;
        v = {(m_state == 2), m_rp[0], m_h[0], m_v[0], 4'(m_p1), 4'(m_p2),
             (m_state == 4), m_winner[0], 3'(m_state)};
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_p1 = 0; m_p2 = 0; m_dx = 1; m_dy = 1; m_cnt = 0;
        m_start_q = 0; m_h = 0; m_v = 0; m_rp = 0; m_winner = 0;
    endtask

    task automatic model_update();
        int  bx, by, q1, q2;
        bit  rise, hit1, hit2, wall, scored;
        if (!reset) begin
            model_reset();
        end else begin
            bx = int'(ball_x); by = int'(ball_y); q1 = int'(p1_y); q2 = int'(p2_y);
            rise = start && (m_start_q == 0);
            m_start_q = start ? 1 : 0;
            m_h = 0; m_v = 0; m_rp = 0;
            case (m_state)
                0: if (rise) begin m_state = 1; m_rp = 1; end
                1: if (tick) begin
                       m_cnt = m_cnt + 1;
                       if (m_cnt == SERVE) begin m_cnt = 0; m_state = 2; end
                   end
                2: if (tick) begin
                       hit1 = (m_dx == 0) && bx <= 40 && bx + 20 >= 30 && by + 20 >= q1 && by <= q1 + 100;
                       hit2 = (m_dx == 1) && bx + 20 >= 600 && bx <= 610 && by + 20 >= q2 && by <= q2 + 100;
                       wall = (m_dy == 0 && by <= 0) || (m_dy == 1 && by >= 460);
                       scored = 0;
                       if (hit1 || hit2) begin
                           m_h = 1; m_dx = 1 - m_dx;
                       end else if (bx < 25) begin
                           if (m_p2 < WIN) m_p2++;
                           m_dx = 0; m_state = 3; scored = 1;
                       end else if (bx > 610) begin
                           if (m_p1 < WIN) m_p1++;
                           m_dx = 1; m_state = 3; scored = 1;
                       end
                       if (wall) begin
                           m_dy = 1 - m_dy;
                           if (!scored) m_v = 1;
                       end
                   end
                3: if (m_p1 == WIN || m_p2 == WIN) begin
                       m_winner = (m_p2 == WIN) ? 1 : 0; m_state = 4;
                   end else begin
                       m_rp = 1; m_dy = 1; m_state = 1;
                   end
                4: if (rise) begin
                       m_p1 = 0; m_p2 = 0; m_dx = 1; m_dy = 1; m_winner = 0;
                       m_rp = 1; m_state = 1;
                   end
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: inputs already applied; sample 1 ns after the edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_ball(input int bx, input int by, input int q1, input int q2);
        ball_x = 10'(bx); ball_y = 9'(by); p1_y = 9'(q1); p2_y = 9'(q2);
    endtask

    task automatic serve_ticks();
        tick = 1'b1;
        for (int i = 0; i < SERVE; i++) cycle();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick = 1'($urandom); start = 1'($urandom);
            set_ball($urandom_range(0, 639), $urandom_range(0, 479),
                     $urandom_range(0, 380), $urandom_range(0, 380));
            cycle();
            n_tests++;
            if (dut_vec !== 17'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 0", dut_vec);
            end
        end
        start = 1'b0; tick = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_start_serve();
        set_ball(300, 150, 100, 100);
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_tests++;
        if (ball_restart !== 1'b1 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL start_serve: restart=%b state=%0d expected 1/1", ball_restart, state);
        end
        tick = 1'b1;
        for (int i = 0; i < SERVE - 1; i++) cycle();
        n_tests++;
        if (state !== 3'd1 || ball_en !== 1'b0) begin
            n_fail++;
            $display("FAIL serve_hold: state=%0d ball_en=%b expected 1/0 after 59 ticks", state, ball_en);
        end
        cycle();
        tick = 1'b0;
        n_tests++;
        if (state !== 3'd2 || ball_en !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_to_play: state=%0d ball_en=%b expected 2/1", state, ball_en);
        end
    endtask

    task automatic test_left_hit();
        set_ball(590, 150, 100, 100);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        n_tests++;
        if (h_col !== 1'b1) begin
            n_fail++;
            $display("FAIL right_bounce: h_col=%b expected 1", h_col);
        end
        cycle();
        set_ball(38, 150, 100, 100);
        tick = 1'b1;
        cycle();
        n_tests++;
        if (h_col !== 1'b1 || v_col !== 1'b0) begin
            n_fail++;
            $display("FAIL left_hit: h_col=%b v_col=%b expected 1/0", h_col, v_col);
        end
        cycle();
        tick = 1'b0;
        n_tests++;
        if (h_col !== 1'b0 || state !== 3'd2) begin
            n_fail++;
            $display("FAIL left_hit_once: h_col=%b state=%0d expected 0/2", h_col, state);
        end
    endtask

    task automatic test_miss_point();
        set_ball(590, 150, 100, 100);
        tick = 1'b1;
        cycle();
        set_ball(20, 400, 0, 100);
        cycle();
        tick = 1'b0;
        n_tests++;
        if (state !== 3'd3 || p2_score !== 4'd1 || p1_score !== 4'd0 || ball_en !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_point: state=%0d p2=%0d p1=%0d expected 3/1/0", state, p2_score, p1_score);
        end
        cycle();
        n_tests++;
        if (state !== 3'd1 || ball_restart !== 1'b1) begin
            n_fail++;
            $display("FAIL point_serve: state=%0d restart=%b expected 1/1", state, ball_restart);
        end
        cycle();
        n_tests++;
        if (ball_restart !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_width: restart=%b expected 0", ball_restart);
        end
    endtask

    task automatic test_corner();
        serve_ticks();
        set_ball(38, 150, 100, 100);
        tick = 1'b1;
        cycle();
        set_ball(585, 460, 100, 380);
        cycle();
        tick = 1'b0;
        n_tests++;
        if (h_col !== 1'b1 || v_col !== 1'b1) begin
            n_fail++;
            $display("FAIL corner: h_col=%b v_col=%b expected 1/1", h_col, v_col);
        end
        cycle();
        n_tests++;
        if (h_col !== 1'b0 || v_col !== 1'b0) begin
            n_fail++;
            $display("FAIL corner_width: h_col=%b v_col=%b expected 0/0", h_col, v_col);
        end
        n_tests++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL corner_model: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random_play();
        int r;
        for (int i = 0; i < 3000; i++) begin
            tick = 1'($urandom);
            if ($urandom_range(0, 29) == 0) start = ~start;
            r = $urandom_range(0, 3);
            if (r == 0)      ball_x = 10'($urandom_range(15, 50));
            else if (r == 1) ball_x = 10'($urandom_range(575, 625));
            else             ball_x = 10'($urandom_range(0, 639));
            r = $urandom_range(0, 7);
            if (r == 0)      ball_y = 9'd0;
            else if (r == 1) ball_y = 9'($urandom_range(455, 479));
            else             ball_y = 9'($urandom_range(0, 479));
            p1_y = 9'($urandom_range(0, 380));
            p2_y = 9'($urandom_range(0, 380));
            cycle();
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random_play cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        start = 1'b0; tick = 1'b0;
        cycle();
    endtask

    task automatic test_win();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        set_ball(620, 150, 100, 100);
        start = 1'b1;
        cycle();
        start = 1'b0;
        tick = 1'b1;
        for (int p = 0; p < WIN; p++) begin
            for (int i = 0; i < SERVE + 2; i++) cycle();
        end
        n_tests++;
        if (state !== 3'd4 || game_over !== 1'b1 || winner !== 1'b0 || p1_score !== 4'd9) begin
            n_fail++;
            $display("FAIL win: state=%0d over=%b winner=%b p1=%0d expected 4/1/0/9",
                     state, game_over, winner, p1_score);
        end
        for (int i = 0; i < 5; i++) cycle();
        n_tests++;
        if (p1_score !== 4'd9 || p2_score !== 4'd0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL win_hold: p1=%0d p2=%0d state=%0d expected 9/0/4", p1_score, p2_score, state);
        end
        tick = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_tests++;
        if (state !== 3'd1 || p1_score !== 4'd0 || game_over !== 1'b0 || ball_restart !== 1'b1) begin
            n_fail++;
            $display("FAIL win_restart: state=%0d p1=%0d over=%b restart=%b expected 1/0/0/1",
                     state, p1_score, game_over, ball_restart);
        end
    endtask

    task automatic test_async_reset();
        set_ball(620, 150, 100, 100);
        serve_ticks();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
        serve_ticks();
        set_ball(590, 150, 100, 100);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        n_tests++;
        if (h_col !== 1'b1 || p1_score !== 4'd1 || ball_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: h_col=%b p1=%0d ball_en=%b expected 1/1/1", h_col, p1_score, ball_en);
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (h_col !== 1'b0 || ball_en !== 1'b0 || p1_score !== 4'd0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: h_col=%b ball_en=%b p1=%0d state=%0d expected 0/0/0/0",
                     h_col, ball_en, p1_score, state);
        end
        cycle();
        reset = 1'b1;
        cycle();
        n_tests++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL post_reset: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    initial begin
        model_reset();
        reset = 1'b0; tick = 1'b0; start = 1'b0;
        set_ball(0, 0, 0, 0);
        test_reset();
        test_start_serve();
        test_left_hit();
        test_miss_point();
        test_corner();
        test_random_play();
        test_win();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
